// File: rtl/time_param_timer.sv
// Time-parameter bank with an integrated seconds-based countdown timer.
// The alarm controller picks a parameter, starts the timer and gets a single-cycle
// expiry pulse back. The programming keypad rewrites parameters through the
// reprogram strobe.
module time_param_timer #(
  parameter int unsigned NUM_PARAMS = 4,
  parameter int unsigned VALUE_W    = 5,
  parameter int unsigned PROG_W     = 4,
  parameter int unsigned CLK_DIV    = 4,
  parameter logic [NUM_PARAMS*VALUE_W-1:0] DEFAULTS = {5'd10, 5'd15, 5'd8, 5'd6},
  localparam int unsigned SEL_W     = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               reprogram,
  input  logic [SEL_W-1:0]   time_param_sel,
  input  logic [PROG_W-1:0]  time_value,
  input  logic [SEL_W-1:0]   interval,
  input  logic               start_timer,
  output logic [VALUE_W-1:0] value,
  output logic [VALUE_W-1:0] remaining,
  output logic               busy,
  output logic               expired
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone
  } state_e;

  logic [VALUE_W-1:0] params_q [NUM_PARAMS];
  logic [VALUE_W-1:0] value_q;
  logic [VALUE_W-1:0] remaining_q;
  logic [DIV_W-1:0]   divider_q;
  state_e             state_q;
  logic               busy_q;
  logic               expired_q;

  logic [VALUE_W-1:0] prog_ext;
  logic               wr_in_range;
  logic               wr_hit;
  logic [VALUE_W-1:0] sel_value;
  logic               tick;

  assign prog_ext = VALUE_W'(time_value);
  assign tick     = (divider_q == DivLast);

  // Decode whether the write select addresses an existing parameter.
  always_comb begin
    wr_in_range = 1'b0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (time_param_sel == SEL_W'(i)) wr_in_range = 1'b1;
    end
  end

  // A write to the parameter being read this cycle is forwarded to the reader.
  assign wr_hit = reprogram && wr_in_range && (time_param_sel == interval);

  // Select param[interval]; out-of-range indices read as zero.
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (interval == SEL_W'(i)) sel_value = params_q[i];
    end
    if (wr_hit) sel_value = prog_ext;
  end

  // Parameter bank: defaults on reset, otherwise indexed writes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        params_q[i] <= DEFAULTS[i*VALUE_W +: VALUE_W];
      end
    end else if (reprogram) begin
      for (int i = 0; i < NUM_PARAMS; i++) begin
        if (time_param_sel == SEL_W'(i)) params_q[i] <= prog_ext;
      end
    end
  end

  // Registered readout of the selected parameter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= sel_value;
    end
  end

  // Countdown FSM with registered busy/expired flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      divider_q   <= '0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else if (start_timer) begin
      // Start (or restart) from any state; an aborted count never pulses.
      remaining_q <= sel_value;
      divider_q   <= '0;
      if (sel_value != '0) begin
        state_q   <= StCount;
        busy_q    <= 1'b1;
        expired_q <= 1'b0;
      end else begin
        state_q   <= StDone;
        busy_q    <= 1'b0;
        expired_q <= 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          busy_q    <= 1'b0;
          expired_q <= 1'b0;
        end
        StCount: begin
          if (tick) begin
            divider_q   <= '0;
            remaining_q <= remaining_q - 1'b1;
            // remaining is >= 1 in this state, so the decrement never wraps.
            if (remaining_q == VALUE_W'(1)) begin
              state_q   <= StDone;
              busy_q    <= 1'b0;
              expired_q <= 1'b1;
            end
          end else begin
            divider_q <= divider_q + 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          expired_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          busy_q    <= 1'b0;
          expired_q <= 1'b0;
        end
      endcase
    end
  end

  assign value     = value_q;
  assign remaining = remaining_q;
  assign busy      = busy_q;
  assign expired   = expired_q;

endmodule
